fwd_scoreboard_buffer: RTL and testbench
========================================

// Module: fwd_scoreboard_buffer
// PURPOSE
//  Parametrised bypass buffer for the dual-issue even/odd pipes. Owns the in-flight result shift registers
//  (addr/data/valid/ready per stage per pipe), captures late completions, forwards the youngest matching
//  result to every register-file read port and flags RAW hazards on not-yet-ready producers. Sits between
//  the register file read and the operand latches; retiring entries drive the register-file write port.
// PARAMETERS
//  NUM_PIPES    2    issue pipes; index 0 = even, 1 = odd
//  DEPTH        9    stages tracked per pipe, stage 0 = youngest
//  NUM_RD       6    register-file read ports serviced
//  ADDR_W       7    register address width
//  DATA_W       128  register data width
//  FLUSH_STAGES 4    stages 0..FLUSH_STAGES-1 are squashable by flush
// PORTS
//  clk        in   1                   clock, rising edge
//  rst_n      in   1                   async active-low reset
//  stall      in   1                   freeze shift of all pipes
//  flush      in   1                   squash speculative stages
//  iss_vld    in   NUM_PIPES           new producer entering stage 0 of pipe p
//  iss_addr   in   NUM_PIPES*ADDR_W    destination register of the new producer
//  cmp_vld    in   NUM_PIPES           execution result available on pipe p
//  cmp_stage  in   NUM_PIPES*$clog2(DEPTH) stage whose entry receives cmp_data
//  cmp_data   in   NUM_PIPES*DATA_W    completion data
//  rd_addr    in   NUM_RD*ADDR_W       read-port register address
//  rd_data_in in   NUM_RD*DATA_W       data from register file
//  rd_data    out  NUM_RD*DATA_W       forwarded or register-file data
//  rd_hazard  out  NUM_RD              youngest match exists but is not ready
//  wb_vld     out  NUM_PIPES           retiring entry write enable
//  wb_addr    out  NUM_PIPES*ADDR_W    retiring register address
//  wb_data    out  NUM_PIPES*DATA_W    retiring data
//  err_unready out 1                   sticky: entry left DEPTH-1 without ready
// BEHAVIOUR
//  - Reset (async, rst_n=0): all valid/ready bits, err_unready and counters clear; rd_hazard=0, wb_vld=0,
//    rd_data=rd_data_in. Reset mid-operation discards every in-flight entry; no writeback issued.
//  - Shift (stall=0): stage s+1 <= stage s; stage 0 <= {iss_vld, iss_addr, ready=0}. stall=1: entries hold,
//    iss_* ignored (issue logic must not issue while stalled).
//  - Completion: cmp_vld with valid entry at cmp_stage sets data and ready, applied at the entry's post-edge
//    position (stage+1 if shifting, same if stalled). Completion to invalid entry dropped.
//  - flush=1: valid cleared in stages 0..FLUSH_STAGES-1 (post-shift); deeper stages continue to retire. Flush
//    wins over same-cycle issue and completion into those stages.
//  - Read (combinational on registered state): candidates = valid entries with addr==rd_addr. Priority:
//    lower stage first; same stage, odd (pipe 1) over even (pipe 0), generalised as higher pipe index wins.
//    Winner ready -> rd_data=entry data, rd_hazard=0; winner not ready -> rd_hazard=1, rd_data=rd_data_in.
//    No candidate -> rd_data_in. Same-cycle issue/completion not visible until next cycle.
//  - Writeback: wb_vld[p] = valid & ready at stage DEPTH-1 & !stall; wb_addr/wb_data from that entry.
//    Valid & !ready at DEPTH-1 with stall=0 -> err_unready set (sticky until reset), no writeback.
//  - No valid bit => no match; address 0 is an ordinary register.
// CONFIGURATION
//  FWD_STATS_EN defined: adds outputs stat_fwd_hits[31:0], stat_hazards[31:0]; per cycle add the number of
//  read ports forwarding / reporting hazard; saturate at 32'hFFFF_FFFF; cleared by reset only.
//  FWD_STATS_EN undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package fwd_pkg: fwd_entry_t {vld, rdy, addr, data}, stage index typedef, priority-order function.
//  Sub-module fwd_match_port (one per read port): priority search over NUM_PIPES*DEPTH entries.
// TESTING
//  1 Reset then read addr 5 with rd_data_in=0xAA -> rd_data=0xAA, rd_hazard=0, wb_vld=0.
//  2 Issue even addr 5, cmp at stage 1 data 0x11, read 5 next cycle -> 0x11; earlier cycle -> rd_hazard=1.
//  3 Same addr 9 in odd stage 2 (0x22) and even stage 2 (0x33), both ready -> rd_data=0x22; add stage 1
//    even 0x44 ready -> 0x44.
//  4 flush with entries at stages 1 and 6 -> stage 1 invisible to reads, stage 6 retires with wb_vld=1.
//  5 stall 3 cycles with entry at DEPTH-1 ready -> wb_vld=0 during stall, single wb pulse after release.
//  6 Entry reaches DEPTH-1 never completed -> err_unready=1, wb_vld=0; assert rst_n low mid-run -> all clear.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: entry record, stage index and the
// priority ordering used by every read-port search.
package fwd_pkg;

   // Storage widths of one entry; module parameters must not exceed these.
   localparam int unsigned MAX_ADDR_W = 7;
   localparam int unsigned MAX_DATA_W = 128;
   localparam int unsigned MAX_DEPTH  = 16;

   typedef logic [$clog2(MAX_DEPTH)-1:0] stage_idx_t;

   typedef struct packed {
      logic                  vld;
      logic                  rdy;
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_DATA_W-1:0] data;
   } fwd_entry_t;

   // Rank 0 is the highest-priority entry: youngest stage first, and within a
   // stage the higher pipe index first.
   function automatic int unsigned prio_rank(input int unsigned stage,
                                             input int unsigned pipe,
                                             input int unsigned num_pipes);
      return stage * num_pipes + (num_pipes - 1 - pipe);
   endfunction

endpackage

// File: rtl/fwd_match_port.sv
// One read port of the forwarding scoreboard: finds the highest-priority valid
// entry whose address matches and either forwards it or flags a hazard.
// Optional feature macro: FWD_STATS_EN (adds the rd_fwd indication).
module fwd_match_port
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_ENT = 18,
   parameter int unsigned ADDR_W  = 7,
   parameter int unsigned DATA_W  = 128
) (
   input  fwd_entry_t        entries [NUM_ENT],
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data_in,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_hazard
`ifdef FWD_STATS_EN
   ,
   output logic              rd_fwd
`endif
);

   logic              found;
   logic              win_rdy;
   logic [DATA_W-1:0] win_data;

   // Entries arrive sorted by rank; scanning downwards leaves the lowest rank.
   always_comb begin
      found    = 1'b0;
      win_rdy  = 1'b0;
      win_data = '0;
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
         if (entries[i].vld && (entries[i].addr == MAX_ADDR_W'(rd_addr))) begin
            found    = 1'b1;
            win_rdy  = entries[i].rdy;
            win_data = entries[i].data[DATA_W-1:0];
         end
      end
   end

   // Forward a ready winner, otherwise fall back to the register file.
   always_comb begin
      rd_data   = (found && win_rdy) ? win_data : rd_data_in;
      rd_hazard = found && !win_rdy;
   end

`ifdef FWD_STATS_EN
   assign rd_fwd = found && win_rdy;
`endif

endmodule

// File: rtl/fwd_scoreboard_buffer.sv
// Bypass buffer for the dual-issue pipes: per-pipe shift registers of in-flight
// results, late completion capture, per-read-port forwarding and writeback.
// Optional feature macro: FWD_STATS_EN (forward/hazard statistics counters).
module fwd_scoreboard_buffer
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_PIPES    = 2,
   parameter int unsigned DEPTH        = 9,
   parameter int unsigned NUM_RD       = 6,
   parameter int unsigned ADDR_W       = 7,
   parameter int unsigned DATA_W       = 128,
   parameter int unsigned FLUSH_STAGES = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            stall,
   input  logic                            flush,
   input  logic [NUM_PIPES-1:0]            iss_vld,
   input  logic [NUM_PIPES*ADDR_W-1:0]     iss_addr,
   input  logic [NUM_PIPES-1:0]            cmp_vld,
   input  logic [NUM_PIPES*$clog2(DEPTH)-1:0] cmp_stage,
   input  logic [NUM_PIPES*DATA_W-1:0]     cmp_data,
   input  logic [NUM_RD*ADDR_W-1:0]        rd_addr,
   input  logic [NUM_RD*DATA_W-1:0]        rd_data_in,
   output logic [NUM_RD*DATA_W-1:0]        rd_data,
   output logic [NUM_RD-1:0]               rd_hazard,
   output logic [NUM_PIPES-1:0]            wb_vld,
   output logic [NUM_PIPES*ADDR_W-1:0]     wb_addr,
   output logic [NUM_PIPES*DATA_W-1:0]     wb_data,
   output logic                            err_unready
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]                     stat_fwd_hits,
   output logic [31:0]                     stat_hazards
`endif
);

   localparam int unsigned STG_W   = $clog2(DEPTH);
   localparam int unsigned NUM_ENT = NUM_PIPES * DEPTH;

   fwd_entry_t pipe_q [NUM_PIPES][DEPTH];
   fwd_entry_t pipe_d [NUM_PIPES][DEPTH];
   fwd_entry_t cand   [NUM_ENT];
   logic       err_q, err_d;

   logic [DEPTH-1:0] cmp_hit  [NUM_PIPES];
   logic [DEPTH-1:0] cmp_land [NUM_PIPES];

   // Locate the completing entry and where it sits after this edge.
   always_comb begin
      for (int p = 0; p < NUM_PIPES; p++) begin
         cmp_hit[p] = '0;
         for (int s = 0; s < DEPTH; s++) begin
            cmp_hit[p][s] = cmp_vld[p] && pipe_q[p][s].vld &&
                            (cmp_stage[p*STG_W +: STG_W] == STG_W'(s));
         end
         cmp_land[p] = stall ? cmp_hit[p] : {cmp_hit[p][DEPTH-2:0], 1'b0};
      end
   end

   // Next state: shift or hold, then completion, then flush (flush wins).
   always_comb begin
      for (int p = 0; p < NUM_PIPES; p++) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (stall) begin
               pipe_d[p][s] = pipe_q[p][s];
            end else if (s == 0) begin
               pipe_d[p][s]      = '0;
               pipe_d[p][s].vld  = iss_vld[p];
               pipe_d[p][s].addr = MAX_ADDR_W'(iss_addr[p*ADDR_W +: ADDR_W]);
            end else begin
               pipe_d[p][s] = pipe_q[p][s-1];
            end
            if (cmp_land[p][s]) begin
               pipe_d[p][s].rdy  = 1'b1;
               pipe_d[p][s].data = MAX_DATA_W'(cmp_data[p*DATA_W +: DATA_W]);
            end
            if (flush && (s < FLUSH_STAGES)) begin
               pipe_d[p][s].vld = 1'b0;
            end
         end
      end
   end

   // Entry and error state; reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PIPES; p++) begin
            for (int s = 0; s < DEPTH; s++) begin
               pipe_q[p][s] <= '0;
            end
         end
         err_q <= 1'b0;
      end else begin
         pipe_q <= pipe_d;
         err_q  <= err_d;
      end
   end

   // Retirement from the oldest stage; an unready oldest entry is an error.
   always_comb begin
      err_d   = err_q;
      wb_vld  = '0;
      wb_addr = '0;
      wb_data = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
         wb_vld[p] = pipe_q[p][DEPTH-1].vld && pipe_q[p][DEPTH-1].rdy && !stall;
         wb_addr[p*ADDR_W +: ADDR_W] = pipe_q[p][DEPTH-1].addr[ADDR_W-1:0];
         wb_data[p*DATA_W +: DATA_W] = pipe_q[p][DEPTH-1].data[DATA_W-1:0];
         if (pipe_q[p][DEPTH-1].vld && !pipe_q[p][DEPTH-1].rdy && !stall) begin
            err_d = 1'b1;
         end
      end
   end

   assign err_unready = err_q;

   // Flatten entries into priority order for the read-port searches.
   always_comb begin
      for (int i = 0; i < NUM_ENT; i++) begin
         cand[i] = '0;
      end
      for (int p = 0; p < NUM_PIPES; p++) begin
         for (int s = 0; s < DEPTH; s++) begin
            cand[prio_rank(s, p, NUM_PIPES)] = pipe_q[p][s];
         end
      end
   end

`ifdef FWD_STATS_EN
   logic [NUM_RD-1:0] rd_fwd;
`endif

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      fwd_match_port #(
         .NUM_ENT (NUM_ENT),
         .ADDR_W  (ADDR_W),
         .DATA_W  (DATA_W)
      ) u_match (
         .entries    (cand),
         .rd_addr    (rd_addr[r*ADDR_W +: ADDR_W]),
         .rd_data_in (rd_data_in[r*DATA_W +: DATA_W]),
         .rd_data    (rd_data[r*DATA_W +: DATA_W]),
         .rd_hazard  (rd_hazard[r])
`ifdef FWD_STATS_EN
         ,
         .rd_fwd     (rd_fwd[r])
`endif
      );
   end

`ifdef FWD_STATS_EN
   logic [31:0] hits_q, haz_q;
   logic [31:0] hits_cnt, haz_cnt;
   logic [32:0] hits_sum, haz_sum;

   // Per-cycle port counts added with saturation.
   always_comb begin
      hits_cnt = '0;
      haz_cnt  = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         hits_cnt = hits_cnt + 32'(rd_fwd[r]);
         haz_cnt  = haz_cnt + 32'(rd_hazard[r]);
      end
      hits_sum = {1'b0, hits_q} + {1'b0, hits_cnt};
      haz_sum  = {1'b0, haz_q} + {1'b0, haz_cnt};
   end

   // Statistics registers, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q <= '0;
         haz_q  <= '0;
      end else begin
         hits_q <= hits_sum[32] ? 32'hFFFF_FFFF : hits_sum[31:0];
         haz_q  <= haz_sum[32] ? 32'hFFFF_FFFF : haz_sum[31:0];
      end
   end

   assign stat_fwd_hits = hits_q;
   assign stat_hazards  = haz_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_buffer.sv
// Self-checking bench for fwd_scoreboard_buffer: read checks inline per
// scenario, writebacks checked against per-pipe expectation queues.
module tb_fwd_scoreboard_buffer;

   localparam int NP = 2;
   localparam int DP = 9;
   localparam int NR = 6;
   localparam int AW = 7;
   localparam int DW = 128;
   localparam int SW = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               stall, flush;
   logic [NP-1:0]      iss_vld;
   logic [NP*AW-1:0]   iss_addr;
   logic [NP-1:0]      cmp_vld;
   logic [NP*SW-1:0]   cmp_stage;
   logic [NP*DW-1:0]   cmp_data;
   logic [NR*AW-1:0]   rd_addr;
   logic [NR*DW-1:0]   rd_data_in;
   logic [NR*DW-1:0]   rd_data;
   logic [NR-1:0]      rd_hazard;
   logic [NP-1:0]      wb_vld;
   logic [NP*AW-1:0]   wb_addr;
   logic [NP*DW-1:0]   wb_data;
   logic               err_unready;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp0[$];
   exp_t exp1[$];
   exp_t e0, e1;

   fwd_scoreboard_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .flush       (flush),
      .iss_vld     (iss_vld),
      .iss_addr    (iss_addr),
      .cmp_vld     (cmp_vld),
      .cmp_stage   (cmp_stage),
      .cmp_data    (cmp_data),
      .rd_addr     (rd_addr),
      .rd_data_in  (rd_data_in),
      .rd_data     (rd_data),
      .rd_hazard   (rd_hazard),
      .wb_vld      (wb_vld),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .err_unready (err_unready)
   );

   always #5 clk = ~clk;

   // Writeback scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wb_vld[0]) begin
            checks++;
            if (exp0.size() == 0) begin
               errors++;
               $display("FAIL wb0_unexpected addr=%0h data=%0h expected none", wb_addr[6:0],
                        wb_data[127:0]);
            end else begin
               e0 = exp0.pop_front();
               if (wb_addr[6:0] !== e0.addr || wb_data[127:0] !== e0.data) begin
                  errors++;
                  $display("FAIL wb0 got addr=%0h data=%0h expected addr=%0h data=%0h",
                           wb_addr[6:0], wb_data[127:0], e0.addr, e0.data);
               end
            end
         end
         if (wb_vld[1]) begin
            checks++;
            if (exp1.size() == 0) begin
               errors++;
               $display("FAIL wb1_unexpected addr=%0h data=%0h expected none", wb_addr[13:7],
                        wb_data[255:128]);
            end else begin
               e1 = exp1.pop_front();
               if (wb_addr[13:7] !== e1.addr || wb_data[255:128] !== e1.data) begin
                  errors++;
                  $display("FAIL wb1 got addr=%0h data=%0h expected addr=%0h data=%0h",
                           wb_addr[13:7], wb_data[255:128], e1.addr, e1.data);
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] rdd(input int r);
      return rd_data[r*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
   endtask

   task automatic set_rd(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rd_addr[r*AW +: AW]    = a;
      rd_data_in[r*DW +: DW] = d;
   endtask

   task automatic test_reset();
      set_rd(0, 7'd5, 128'hAA);
      #2;
      checks++;
      if (rdd(0) !== 128'hAA) begin
         errors++; $display("FAIL reset_rd_data got=%0h expected=aa", rdd(0));
      end
      checks++;
      if (rd_hazard !== 6'b0) begin
         errors++; $display("FAIL reset_hazard got=%b expected=0", rd_hazard);
      end
      checks++;
      if (wb_vld !== 2'b0 || err_unready !== 1'b0) begin
         errors++; $display("FAIL reset_wb_err got wb=%b err=%b expected 0", wb_vld, err_unready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_forward();
      iss_vld = 2'b01; iss_addr[6:0] = 7'd5;
      tick();
      iss_vld = 2'b00;
      set_rd(0, 7'd5, 128'hAA);
      set_rd(1, 7'd6, 128'h55);
      #1;
      checks++;
      if (rd_hazard[0] !== 1'b1 || rdd(0) !== 128'hAA) begin
         errors++; $display("FAIL fwd_unready got hz=%b data=%0h expected hz=1 data=aa",
                            rd_hazard[0], rdd(0));
      end
      checks++;
      if (rd_hazard[1] !== 1'b0 || rdd(1) !== 128'h55) begin
         errors++; $display("FAIL fwd_nomatch got hz=%b data=%0h expected hz=0 data=55",
                            rd_hazard[1], rdd(1));
      end
      tick();
      cmp_vld = 2'b01; cmp_stage[3:0] = 4'd1; cmp_data[127:0] = 128'h11;
      exp0.push_back('{addr: 7'd5, data: 128'h11});
      #1;
      checks++;
      if (rd_hazard[0] !== 1'b1) begin
         errors++; $display("FAIL fwd_same_cycle got hz=%b expected hz=1", rd_hazard[0]);
      end
      tick();
      cmp_vld = 2'b00;
      #1;
      checks++;
      if (rd_hazard[0] !== 1'b0 || rdd(0) !== 128'h11) begin
         errors++; $display("FAIL fwd_ready got hz=%b data=%0h expected hz=0 data=11",
                            rd_hazard[0], rdd(0));
      end
      drain(DP + 1);
   endtask

   task automatic test_priority();
      iss_vld = 2'b11; iss_addr = {7'd9, 7'd9};
      tick();
      iss_vld = 2'b00;
      tick();
      cmp_vld = 2'b11; cmp_stage = {4'd1, 4'd1};
      cmp_data = {128'h22, 128'h33};
      exp0.push_back('{addr: 7'd9, data: 128'h33});
      exp1.push_back('{addr: 7'd9, data: 128'h22});
      tick();
      cmp_vld = 2'b00;
      set_rd(0, 7'd9, 128'hAA);
      set_rd(5, 7'd9, 128'hBB);
      #1;
      checks++;
      if (rdd(0) !== 128'h22 || rd_hazard[0] !== 1'b0) begin
         errors++; $display("FAIL prio_odd_over_even got data=%0h hz=%b expected data=22 hz=0",
                            rdd(0), rd_hazard[0]);
      end
      checks++;
      if (rdd(5) !== 128'h22) begin
         errors++; $display("FAIL prio_port5 got=%0h expected=22", rdd(5));
      end
      iss_vld = 2'b01; iss_addr[6:0] = 7'd9;
      tick();
      iss_vld = 2'b00;
      #1;
      checks++;
      if (rd_hazard[0] !== 1'b1 || rdd(0) !== 128'hAA) begin
         errors++; $display("FAIL prio_young_unready got hz=%b data=%0h expected hz=1 data=aa",
                            rd_hazard[0], rdd(0));
      end
      cmp_vld = 2'b01; cmp_stage[3:0] = 4'd0; cmp_data[127:0] = 128'h44;
      exp0.push_back('{addr: 7'd9, data: 128'h44});
      tick();
      cmp_vld = 2'b00;
      #1;
      checks++;
      if (rdd(0) !== 128'h44 || rd_hazard[0] !== 1'b0) begin
         errors++; $display("FAIL prio_younger_stage got data=%0h hz=%b expected data=44 hz=0",
                            rdd(0), rd_hazard[0]);
      end
      drain(DP + 1);
   endtask

   task automatic test_flush();
      iss_vld = 2'b01; iss_addr[6:0] = 7'd12;
      tick();
      iss_vld = 2'b00;
      cmp_vld = 2'b01; cmp_stage[3:0] = 4'd0; cmp_data[127:0] = 128'h66;
      exp0.push_back('{addr: 7'd12, data: 128'h66});
      tick();
      cmp_vld = 2'b00;
      drain(3);
      iss_vld = 2'b10; iss_addr[13:7] = 7'd13;
      tick();
      iss_vld = 2'b00;
      cmp_vld = 2'b10; cmp_stage[7:4] = 4'd0; cmp_data[255:128] = 128'h77;
      tick();
      cmp_vld = 2'b00;
      set_rd(1, 7'd13, 128'hCC);
      set_rd(2, 7'd12, 128'hDD);
      set_rd(3, 7'd14, 128'hEE);
      #1;
      checks++;
      if (rdd(1) !== 128'h77) begin
         errors++; $display("FAIL flush_pre got=%0h expected=77", rdd(1));
      end
      flush = 1'b1;
      iss_vld = 2'b01; iss_addr[6:0] = 7'd14;
      cmp_vld = 2'b10; cmp_stage[7:4] = 4'd1; cmp_data[255:128] = 128'h99;
      tick();
      flush = 1'b0; iss_vld = 2'b00; cmp_vld = 2'b00;
      #1;
      checks++;
      if (rdd(1) !== 128'hCC || rd_hazard[1] !== 1'b0) begin
         errors++; $display("FAIL flush_squashed got data=%0h hz=%b expected data=cc hz=0",
                            rdd(1), rd_hazard[1]);
      end
      checks++;
      if (rdd(2) !== 128'h66) begin
         errors++; $display("FAIL flush_deep_kept got=%0h expected=66", rdd(2));
      end
      checks++;
      if (rdd(3) !== 128'hEE || rd_hazard[3] !== 1'b0) begin
         errors++; $display("FAIL flush_issue got data=%0h hz=%b expected data=ee hz=0",
                            rdd(3), rd_hazard[3]);
      end
      drain(DP + 1);
   endtask

   task automatic test_stall();
      iss_vld = 2'b10; iss_addr[13:7] = 7'd20;
      tick();
      iss_vld = 2'b00;
      cmp_vld = 2'b10; cmp_stage[7:4] = 4'd0; cmp_data[255:128] = 128'h88;
      exp1.push_back('{addr: 7'd20, data: 128'h88});
      tick();
      cmp_vld = 2'b00;
      drain(DP - 2);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (wb_vld !== 2'b00) begin
            errors++; $display("FAIL stall_wb cycle=%0d got=%b expected=00", i, wb_vld);
         end
         tick();
      end
      set_rd(4, 7'd20, 128'h1);
      #1;
      checks++;
      if (rdd(4) !== 128'h88) begin
         errors++; $display("FAIL stall_hold got=%0h expected=88", rdd(4));
      end
      stall = 1'b0;
      #1;
      checks++;
      if (wb_vld !== 2'b10) begin
         errors++; $display("FAIL stall_release got=%b expected=10", wb_vld);
      end
      tick();
      #1;
      checks++;
      if (wb_vld !== 2'b00) begin
         errors++; $display("FAIL stall_single_pulse got=%b expected=00", wb_vld);
      end
      drain(2);
   endtask

   task automatic test_err_reset();
      checks++;
      if (err_unready !== 1'b0) begin
         errors++; $display("FAIL err_clean got=%b expected=0", err_unready);
      end
      iss_vld = 2'b01; iss_addr[6:0] = 7'd30;
      tick();
      iss_vld = 2'b00;
      drain(DP - 1);
      set_rd(2, 7'd30, 128'h3);
      #1;
      checks++;
      if (wb_vld[0] !== 1'b0 || err_unready !== 1'b0 || rd_hazard[2] !== 1'b1) begin
         errors++; $display("FAIL err_at_last got wb=%b err=%b hz=%b expected wb=0 err=0 hz=1",
                            wb_vld[0], err_unready, rd_hazard[2]);
      end
      tick();
      checks++;
      if (err_unready !== 1'b1) begin
         errors++; $display("FAIL err_set got=%b expected=1", err_unready);
      end
      tick();
      checks++;
      if (err_unready !== 1'b1) begin
         errors++; $display("FAIL err_sticky got=%b expected=1", err_unready);
      end
      iss_vld = 2'b10; iss_addr[13:7] = 7'd31;
      tick();
      iss_vld = 2'b00;
      cmp_vld = 2'b10; cmp_stage[7:4] = 4'd0; cmp_data[255:128] = 128'hBE;
      tick();
      cmp_vld = 2'b00;
      set_rd(0, 7'd31, 128'h12);
      #1;
      checks++;
      if (rdd(0) !== 128'hBE) begin
         errors++; $display("FAIL err_inflight got=%0h expected=be", rdd(0));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (err_unready !== 1'b0 || rdd(0) !== 128'h12 || rd_hazard !== 6'b0 || wb_vld !== 2'b0)
      begin
         errors++; $display("FAIL midrun_reset got err=%b data=%0h hz=%b wb=%b expected 0/12/0/0",
                            err_unready, rdd(0), rd_hazard, wb_vld);
      end
      drain(2);
      @(negedge clk);
      rst_n = 1'b1;
      drain(DP + 2);
      checks++;
      if (err_unready !== 1'b0) begin
         errors++; $display("FAIL post_reset_err got=%b expected=0", err_unready);
      end
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         errors++; $display("FAIL wb_missing got pending=%0d/%0d expected 0/0",
                            exp0.size(), exp1.size());
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      iss_vld    = '0;
      iss_addr   = '0;
      cmp_vld    = '0;
      cmp_stage  = '0;
      cmp_data   = '0;
      rd_addr    = '0;
      rd_data_in = '0;
      for (int r = 0; r < NR; r++) set_rd(r, 7'd127, 128'(r + 16'hF00));
      test_reset();
      test_forward();
      test_priority();
      test_flush();
      test_stall();
      test_err_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
